matmul_row_col_seq: RTL and testbench
=====================================

Name: matmul_row_col_seq

Overview:
- Sequencer for 5x5 signed 8-bit matrix product C = A x B.
- Latches packed A and B, then walks the 25 (i,j) index pairs in order.
- For each pair it drives row i of A and column j of B to the external combinational inner-product unit, and captures that unit's result and overflow into packed C.
- It is the producer and collector on the other end of the inner-product unit's lin/col/n_out/ovf interface, and sits between the coprocessor command path and that unit.

Parameters:
- DIM, 5, matrix dimension; the inner-product unit is fixed to 5, so only 5 is supported.
- EW, 8, element width in bits (signed two's complement).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle request; sampled only in IDLE.
- a_mat  in  200  matrix A; element (r,c) at bits [199-8*(5r+c) -: 8], row-major, MSB-first.
- b_mat  in  200  matrix B, same packing as A.
- lin_o  out  40  row i of latched A; element k at [39-8k -: 8], so element 0 is in [39:32].
- col_o  out  40  column j of latched B, i.e. B(k,j) at [39-8k -: 8].
- prod_i  in  8  inner-product result for the currently driven lin_o/col_o.
- prod_ovf_i  in  1  inner-product overflow for the currently driven pair.
- c_mat  out  200  result matrix, same packing as A.
- ovf  out  1  sticky OR of prod_ovf_i over the current or last run.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when C is complete.

Behaviour:
- Reset values: c_mat=0, ovf=0, busy=0, done=0, idx=0, latched A/B=0, state IDLE. lin_o/col_o derive from the latched regs, so they are 0 after reset.
- States are IDLE, RUN, DONE.
- IDLE: on start=1, latch a_mat/b_mat, clear c_mat and ovf, set idx=0, go to RUN.
- start is ignored in RUN and DONE; there is no queueing.
- RUN, every cycle:
  - i=idx/5, j=idx%5.
  - lin_o/col_o are a combinational mux of the latched regs indexed by i,j.
  - At the clock edge: store prod_i into c_mat element (i,j), ovf <= ovf | prod_ovf_i, idx <= idx+1.
  - When idx==24 is captured, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- Timing from the start edge: busy high for 25 cycles, done high in cycle 26, next start accepted in cycle 27.
- c_mat and ovf hold their values until the next accepted start.
- Arithmetic: there is none in this block. Elements are copied bit-exact; wrap and overflow semantics belong entirely to the inner-product unit.
- Boundary, reset mid-RUN: all state returns to reset values the next cycle; done is never pulsed and partial C is discarded to 0.
- Boundary, rst and start in the same cycle: rst wins.
- Boundary, idx: counts 0..24 and never wraps; the DONE transition is taken at 24.
- Boundary, a_mat/b_mat changes during RUN: no effect, because operands are latched.
- Combinational path: latched regs -> mux -> external unit -> prod_i -> c_mat register. It must close in one cycle at the system clock.

Optional Feature:
- Macro: MATMUL_SEQ_OVF_MAP_EN.
- Defined: adds output ovf_map [24:0] with reset value 0.
  - Bit 24-idx captures prod_ovf_i for element idx, so element (0,0) is the MSB.
  - Cleared on accepted start; held until the next start.
  - ovf equals |ovf_map.
- Undefined: port and logic are absent; only the sticky ovf exists.

Decomposition:
- Package matmul_pkg holds:
  - DIM and EW.
  - ROW_W=40 and MAT_W=200.
  - The state enum {IDLE, RUN, DONE}.
  - The element-offset function off(r,c)=MAT_W-1-EW*(DIM*r+c).
- Sub-module mat_col_gather: combinational extraction of column j from a packed 200-bit matrix into 40-bit col format. It is reusable by the transpose op.
- The inner-product unit is not instantiated here; the parent connects the two blocks.

Test Plan:
- Identity x B (B elements 1..25): with the real inner-product unit attached, c_mat==b_mat; ovf=0; busy high for 25 cycles; done in cycle 26.
- All A=2, all B=3: every C element is 0x1E (30); ovf=0.
- All A=10, all B=10: every element is 500 wrapped to 0xF4; ovf=1. With MATMUL_SEQ_OVF_MAP_EN, ovf_map=25'h1FFFFFF.
- A=-1 everywhere, B=identity: every C element is 0xFF (-1); ovf=0. Then pulse start again during RUN: ignored, exactly one done pulse.
- Assert rst when idx==10: the next cycle c_mat=0, busy=0, ovf=0, no done. A subsequent start completes correctly.
- Forced stub with prod_ovf_i=1 only at idx 7 (i=1,j=2): ovf=1; ovf_map bit 17 is the only set bit.

Source files
------------

// File: rtl/matmul_row_col_seq_pkg.sv
// matmul_pkg: shared sizes, state encoding and packed-matrix offset helper
// for the 5x5 row/column sequencer.
// Packing: element (r,c) lives at bits [off(r,c) -: EW], row-major, MSB-first.
package matmul_pkg;
    localparam int DIM    = 5;
    localparam int EW     = 8;
    localparam int ROW_W  = DIM * EW;
    localparam int MAT_W  = DIM * ROW_W;
    localparam int N_ELEM = DIM * DIM;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // MSB index of element (r,c) inside a packed MAT_W-bit matrix
    function automatic int off(input int r, input int c);
        return MAT_W - 1 - EW * (DIM * r + c);
    endfunction
endpackage

// File: rtl/matmul_row_col_seq_if.sv
// matmul_row_col_seq_if: command/result bus plus the lin/col/prod link to the
// external inner-product unit.
//   master : coprocessor side (drives start, operands, inner-product result)
//   slave  : the sequencer
// Optional macro MATMUL_SEQ_OVF_MAP_EN adds the per-element overflow map.
interface matmul_row_col_seq_if;
    import matmul_pkg::*;

    logic             start;
    logic [MAT_W-1:0] a_mat;
    logic [MAT_W-1:0] b_mat;
    logic [ROW_W-1:0] lin_o;
    logic [ROW_W-1:0] col_o;
    logic [EW-1:0]    prod_i;
    logic             prod_ovf_i;
    logic [MAT_W-1:0] c_mat;
    logic             ovf;
    logic             busy;
    logic             done;
`ifdef MATMUL_SEQ_OVF_MAP_EN
    logic [N_ELEM-1:0] ovf_map;

    modport master (output start, a_mat, b_mat, prod_i, prod_ovf_i,
                    input  lin_o, col_o, c_mat, ovf, busy, done, ovf_map);
    modport slave  (input  start, a_mat, b_mat, prod_i, prod_ovf_i,
                    output lin_o, col_o, c_mat, ovf, busy, done, ovf_map);
`else
    modport master (output start, a_mat, b_mat, prod_i, prod_ovf_i,
                    input  lin_o, col_o, c_mat, ovf, busy, done);
    modport slave  (input  start, a_mat, b_mat, prod_i, prod_ovf_i,
                    output lin_o, col_o, c_mat, ovf, busy, done);
`endif
endinterface

// File: rtl/matmul_row_col_seq_col_gather.sv
// mat_col_gather: combinational extraction of column j from a packed DIMxDIM
// matrix into row format (element k of the column at [ROW_W-1-EW*k -: EW]).
// Ports: mat (packed matrix in), j (column index in), col (column out).
// Out-of-range j yields zero.
module mat_col_gather
    import matmul_pkg::*;
(
    input  logic [MAT_W-1:0] mat,
    input  logic [2:0]       j,
    output logic [ROW_W-1:0] col
);
    // Pick element (k,j) of every row k
    always_comb begin
        col = {ROW_W{1'b0}};
        if (j < 3'd5) begin
            for (int k = 0; k < DIM; k++) begin
                col[ROW_W - 1 - EW * k -: EW] = mat[off(k, int'(j)) -: EW];
            end
        end else begin
            col = {ROW_W{1'b0}};
        end
    end
endmodule

// File: rtl/matmul_row_col_seq.sv
// matmul_row_col_seq: sequencer for C = A x B over 5x5 signed 8-bit matrices.
// Latches A/B on start, then for idx = 0..24 drives row i=idx/5 of A and
// column j=idx%5 of B to an external combinational inner-product unit and
// captures its result/overflow into C. busy is high for the 25 RUN cycles,
// done pulses for one cycle afterwards.
// Ports: clk, rst (sync, active-high), bus (matmul_row_col_seq_if.slave).
// Optional macro MATMUL_SEQ_OVF_MAP_EN: adds ovf_map, bit 24-idx holding the
// overflow flag of element idx.
module matmul_row_col_seq
    import matmul_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    matmul_row_col_seq_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_RUN  = 2'(RUN);
    localparam logic [1:0] ST_DONE = 2'(DONE);
    localparam logic [4:0] LAST_IDX = 5'd24;

    logic [1:0]       state_r;
    logic [4:0]       idx_r;
    logic [MAT_W-1:0] a_r;
    logic [MAT_W-1:0] b_r;
    logic [MAT_W-1:0] c_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;
    logic [2:0]       i_s;
    logic [2:0]       j_s;
    logic [ROW_W-1:0] lin_s;
    logic [ROW_W-1:0] col_s;
`ifdef MATMUL_SEQ_OVF_MAP_EN
    logic [N_ELEM-1:0] ovf_map_r;
`endif

    assign i_s = 3'(idx_r / 5'd5);
    assign j_s = 3'(idx_r % 5'd5);

    // Row i of the latched A; rows are contiguous so this is a single slice
    always_comb begin
        lin_s = {ROW_W{1'b0}};
        if (i_s < 3'd5) begin
            lin_s = a_r[off(int'(i_s), 0) -: ROW_W];
        end else begin
            lin_s = {ROW_W{1'b0}};
        end
    end

    mat_col_gather u_col_gather (
        .mat (b_r),
        .j   (j_s),
        .col (col_s)
    );

    // Control FSM, operand latches and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= 5'd0;
            a_r     <= {MAT_W{1'b0}};
            b_r     <= {MAT_W{1'b0}};
            c_r     <= {MAT_W{1'b0}};
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef MATMUL_SEQ_OVF_MAP_EN
            ovf_map_r <= {N_ELEM{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_r     <= bus.a_mat;
                        b_r     <= bus.b_mat;
                        c_r     <= {MAT_W{1'b0}};
                        ovf_r   <= 1'b0;
                        idx_r   <= 5'd0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
`ifdef MATMUL_SEQ_OVF_MAP_EN
                        ovf_map_r <= {N_ELEM{1'b0}};
`endif
                    end
                end
                ST_RUN: begin
                    c_r[off(int'(i_s), int'(j_s)) -: EW] <= bus.prod_i;
                    ovf_r <= ovf_r | bus.prod_ovf_i;
`ifdef MATMUL_SEQ_OVF_MAP_EN
                    ovf_map_r[LAST_IDX - idx_r] <= bus.prod_ovf_i;
`endif
                    // idx saturates at the last element; it never wraps
                    if (idx_r == LAST_IDX) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        idx_r <= idx_r + 5'd1;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.lin_o = lin_s;
    assign bus.col_o = col_s;
    assign bus.c_mat = c_r;
    assign bus.ovf   = ovf_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
`ifdef MATMUL_SEQ_OVF_MAP_EN
    assign bus.ovf_map = ovf_map_r;
`endif
endmodule

// File: tb/tb_matmul_row_col_seq.sv
// Directed bench for matmul_row_col_seq. Acts as the external inner-product
// unit (signed dot product, 8-bit wrap, overflow when the exact sum leaves
// [-128,127]) with an optional stub that flags overflow at one index only.
module tb_matmul_row_col_seq;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   stub_mode;
    int   stub_idx;
    int   model_sum;
    int   busy_cyc;
    int   done_cyc;
    int   done_cnt;

    matmul_row_col_seq_if bus ();

    matmul_row_col_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Inner-product unit model
    always_comb begin
        model_sum = 0;
        for (int k = 0; k < 5; k++) begin
            model_sum = model_sum + int'($signed(bus.lin_o[39 - 8 * k -: 8])) *
                                    int'($signed(bus.col_o[39 - 8 * k -: 8]));
        end
        bus.prod_i = model_sum[7:0];
        if (stub_mode) begin
            bus.prod_ovf_i = (stub_idx == 7);
        end else begin
            bus.prod_ovf_i = (model_sum > 127) || (model_sum < -128);
        end
    end

    function automatic logic [199:0] fill(input logic [7:0] v);
        logic [199:0] m;
        m = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                m[199 - 8 * (5 * r + c) -: 8] = v;
        return m;
    endfunction

    function automatic logic [199:0] ident();
        logic [199:0] m;
        m = '0;
        for (int r = 0; r < 5; r++)
            m[199 - 8 * (5 * r + r) -: 8] = 8'd1;
        return m;
    endfunction

    function automatic logic [199:0] seq_b();
        logic [199:0] m;
        m = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                m[199 - 8 * (5 * r + c) -: 8] = 8'(5 * r + c + 1);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one run, scramble the operand inputs, and watch 30 cycles
    task automatic run(input logic [199:0] a, input logic [199:0] b, input bit poke);
        bus.a_mat = a;
        bus.b_mat = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a_mat = ~a;
        bus.b_mat = ~b;
        stub_idx = 0;
        busy_cyc = 0;
        done_cyc = 0;
        done_cnt = 0;
        for (int n = 1; n <= 30; n++) begin
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = n;
            end
            bus.start = (poke && (n == 5 || n == 26));
            tick();
            stub_idx++;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        stub_mode = 1'b0;
        stub_idx = 0;
        bus.start = 1'b0;
        bus.a_mat = '0;
        bus.b_mat = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_c", bus.c_mat, '0);
        chk("rst_ovf", 200'(bus.ovf), '0);
        chk("rst_busy", 200'(bus.busy), '0);
        chk("rst_done", 200'(bus.done), '0);
        chk("rst_lin", 200'(bus.lin_o), '0);
        chk("rst_col", 200'(bus.col_o), '0);
`ifdef MATMUL_SEQ_OVF_MAP_EN
        chk("rst_map", 200'(bus.ovf_map), '0);
`endif

        // rst and start together: rst wins
        rst = 1'b1;
        bus.start = 1'b1;
        bus.a_mat = fill(8'd2);
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        chk("rst_start_busy", 200'(bus.busy), '0);
        tick();
        chk("rst_start_busy2", 200'(bus.busy), '0);

        // Identity x B
        run(ident(), seq_b(), 1'b0);
        chk("id_c", bus.c_mat, seq_b());
        chk("id_ovf", 200'(bus.ovf), '0);
        chk("id_busy_cyc", 200'(busy_cyc), 200'(25));
        chk("id_done_cyc", 200'(done_cyc), 200'(26));
        chk("id_done_cnt", 200'(done_cnt), 200'(1));
        repeat (4) tick();
        chk("id_hold_c", bus.c_mat, seq_b());

        // All 2 x all 3
        run(fill(8'd2), fill(8'd3), 1'b0);
        chk("two_three_c", bus.c_mat, fill(8'h1E));
        chk("two_three_ovf", 200'(bus.ovf), '0);

        // All 10 x all 10: 500 wraps to 0xF4
        run(fill(8'd10), fill(8'd10), 1'b0);
        chk("ten_c", bus.c_mat, fill(8'hF4));
        chk("ten_ovf", 200'(bus.ovf), 200'(1));
`ifdef MATMUL_SEQ_OVF_MAP_EN
        chk("ten_map", 200'(bus.ovf_map), 200'(25'h1FFFFFF));
`endif

        // -1 x identity with start poked during RUN and DONE
        run(fill(8'hFF), ident(), 1'b1);
        chk("neg_c", bus.c_mat, fill(8'hFF));
        chk("neg_ovf", 200'(bus.ovf), '0);
        chk("neg_busy_cyc", 200'(busy_cyc), 200'(25));
        chk("neg_done_cnt", 200'(done_cnt), 200'(1));
        tick();
        chk("neg_poke_busy", 200'(bus.busy), '0);

        // Reset at idx 10 of an overflowing run
        bus.a_mat = fill(8'd10);
        bus.b_mat = fill(8'd10);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        chk("mid_busy_pre", 200'(bus.busy), 200'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_c", bus.c_mat, '0);
        chk("mid_busy", 200'(bus.busy), '0);
        chk("mid_ovf", 200'(bus.ovf), '0);
        chk("mid_done", 200'(bus.done), '0);
        done_cnt = 0;
        for (int n = 0; n < 30; n++) begin
            if (bus.done) done_cnt++;
            tick();
        end
        chk("mid_no_done", 200'(done_cnt), '0);
        run(ident(), seq_b(), 1'b0);
        chk("mid_after_c", bus.c_mat, seq_b());
        chk("mid_after_done_cyc", 200'(done_cyc), 200'(26));

        // Stub: overflow only at idx 7 (i=1,j=2)
        stub_mode = 1'b1;
        run(fill(8'd2), fill(8'd3), 1'b0);
        chk("stub_ovf", 200'(bus.ovf), 200'(1));
        chk("stub_c", bus.c_mat, fill(8'h1E));
`ifdef MATMUL_SEQ_OVF_MAP_EN
        chk("stub_map", 200'(bus.ovf_map), 200'(25'h0020000));
`endif
        stub_mode = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
